// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: frame geometry, luma weights and the capture FSM encoding.
package img_pkg;
    localparam int unsigned FRAME_W = 640;
    localparam int unsigned FRAME_H = 480;

    localparam int unsigned LUMA_R = 77;
    localparam int unsigned LUMA_G = 150;
    localparam int unsigned LUMA_B = 29;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } cap_state_t;

    // Weights sum to 256, so the 16-bit sum peaks at 65280 and never overflows.
    function automatic logic [7:0] luma8(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [15:0] sum;
        sum = 16'(LUMA_R) * 16'(r) + 16'(LUMA_G) * 16'(g) + 16'(LUMA_B) * 16'(b);
        return 8'(sum >> 8);
    endfunction
endpackage

// File: rtl/frame_capture_if.sv
// RGB888 pixel stream with valid/ready handshake, from camera source to frame capture.
interface frame_capture_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;

    modport master (output in_valid, output in_r, output in_g, output in_b, input in_ready);
    modport slave  (input in_valid, input in_r, input in_g, input in_b, output in_ready);
endinterface

// File: rtl/frame_ram.sv
// Frame store: one write port and one registered read port (read-before-write on collision).
module frame_ram #(
    parameter int unsigned DEPTH = 307200,
    parameter int unsigned AW    = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past the frame read as zero rather than indexing off the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (32'(raddr) < DEPTH) begin
            rd_data <= mem[raddr];
        end else begin
            rd_data <= '0;
        end
    end
endmodule

// File: rtl/frame_capture.sv
// Captures one raster frame of RGB888 pixels as 8-bit luma into frame_ram.
// The frame hand-back pulse is named frame_release because "release" is a reserved word.
module frame_capture
    import img_pkg::*;
#(
    parameter int unsigned WIDTH  = FRAME_W,
    parameter int unsigned HEIGHT = FRAME_H,
    parameter int unsigned AW     = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    frame_capture_if.slave  pix,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun,
    input  logic            frame_release,
    input  logic [AW-1:0]   rd_addr,
    output logic [7:0]      rd_data
);
    localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    cap_state_t    state, state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last_accepted;
    logic          accept;
    logic          at_last;
    logic          arm;

    logic [7:0]    gray_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic          last_q;

    assign accept  = pix.in_valid && pix.in_ready;
    assign at_last = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));
    assign arm     = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)          state_nxt = CAPTURE;
            CAPTURE: if (we_q && last_q) state_nxt = DONE;
            DONE:    if (frame_release)  state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix.in_ready = (state == CAPTURE) && !last_accepted;
        busy         = (state == CAPTURE);
        frame_done   = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x             <= '0;
            y             <= '0;
            last_accepted <= 1'b0;
        end else if (arm) begin
            x             <= '0;
            y             <= '0;
            last_accepted <= 1'b0;
        end else if (accept) begin
            last_accepted <= at_last;
            if (x == XW'(WIDTH - 1)) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // A refused offer in the same cycle as start still latches the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (pix.in_valid && !pix.in_ready) begin
            overrun <= 1'b1;
        end else if (arm) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            last_q <= 1'b0;
            gray_q <= '0;
            addr_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                gray_q <= luma8(pix.in_r, pix.in_g, pix.in_b);
                addr_q <= AW'(y) * AW'(WIDTH) + AW'(x);
                last_q <= at_last;
            end
        end
    end

    // Gating with rst drops a write still in flight when reset lands mid-capture.
    frame_ram #(
        .DEPTH (WIDTH * HEIGHT),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (we_q && !rst),
        .waddr   (addr_q),
        .wdata   (gray_q),
        .raddr   (rd_addr),
        .rd_data (rd_data)
    );
endmodule
